bpsk_demodulator: RTL and testbench

//  Coherent BPSK receiver, the receive-side counterpart of bpsk_modulator. Correlates each

---
 rtl/bpsk_demodulator.sv | 155 +++++++++++++++
 tb/tb_bpsk_demodulator.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_demodulator.sv
// Coherent BPSK demodulator: correlates each received sample against the shared
// sine reference, integrates over one symbol, slices the sign into a bit and
// packs DATA_WIDTH bits (MSB first) into an output word.
module bpsk_demodulator #(
    parameter int SAMPLE_NUMBER = 256,
    parameter int SAMPLE_WIDTH  = 12,
    parameter int DATA_WIDTH    = 12,
    localparam int CNT_WIDTH    = $clog2(SAMPLE_NUMBER)
) (
    input  logic                           clk,
    input  logic                           arst,
    input  logic                           en,
    input  logic signed [SAMPLE_WIDTH-1:0] signal_in,
    input  logic signed [SAMPLE_WIDTH-1:0] sine_in,
    input  logic        [CNT_WIDTH-1:0]    cnt_in,
    output logic                           bit_out,
    output logic                           bit_valid,
    output logic        [DATA_WIDTH-1:0]   data_out,
    output logic                           data_valid
);

    localparam int PROD_WIDTH = 2 * SAMPLE_WIDTH;
    localparam int ACC_WIDTH  = PROD_WIDTH + CNT_WIDTH;
    localparam int BC_WIDTH   = $clog2(DATA_WIDTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                        state_q, state_d;

    // Stage 1: product and symbol-boundary flags
    logic signed [PROD_WIDTH-1:0]  prod_q, prod_d;
    logic                          first_q, first_d;
    logic                          last_q, last_d;
    logic                          s1_vld_q, s1_vld_d;

    // Stage 2: integrator
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                          s2_vld_q, s2_vld_d;

    // Stage 3: slicer and word assembly
    logic [DATA_WIDTH-1:0]         shift_q, shift_d;
    logic [BC_WIDTH-1:0]           bit_cnt_q, bit_cnt_d;
    logic                          bit_out_q, bit_out_d;
    logic                          bit_valid_q, bit_valid_d;
    logic [DATA_WIDTH-1:0]         data_out_q, data_out_d;
    logic                          data_valid_q, data_valid_d;

    logic                          cnt_is_first;
    logic                          cnt_is_last;
    logic                          upd1;
    logic                          upd2;
    logic                          sliced;
    logic signed [ACC_WIDTH-1:0]   acc_next;
    logic [DATA_WIDTH-1:0]         shift_next;

    // FSM next state: enter RUN only on a symbol boundary, leave as soon as en drops
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (en && cnt_is_first) state_d = RUN;
            RUN:  if (!en)                state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // Datapath next-state for all three pipeline stages
    always_comb begin
        cnt_is_first = (cnt_in == '0);
        cnt_is_last  = (cnt_in == CNT_WIDTH'(SAMPLE_NUMBER - 1));

        // Stage 1: a sample is consumed when running, or on the boundary that starts a run
        s1_vld_d = en && ((state_q == RUN) || cnt_is_first);
        prod_d   = PROD_WIDTH'(signal_in) * PROD_WIDTH'(sine_in);
        first_d  = cnt_is_first;
        last_d   = cnt_is_last;

        // Stage 2: a first sample restarts integration, which also absorbs any
        // cnt_in discontinuity without emitting a bit
        upd1     = s1_vld_q && en;
        acc_next = first_q ? ACC_WIDTH'(prod_q) : acc_q + ACC_WIDTH'(prod_q);
        acc_d    = upd1 ? acc_next : acc_q;
        s2_vld_d = upd1 && last_q;

        // Stage 3: the completed symbol sum sits in acc_q for exactly one cycle
        upd2       = s2_vld_q && en;
        sliced     = !acc_q[ACC_WIDTH-1] && (acc_q != '0);
        shift_next = {shift_q[DATA_WIDTH-2:0], sliced};

        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        bit_out_d    = bit_out_q;
        bit_valid_d  = 1'b0;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;

        if (!en) begin
            // Abort: drop the partial word; outputs keep their last values
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (upd2) begin
            shift_d     = shift_next;
            bit_out_d   = sliced;
            bit_valid_d = 1'b1;
            if (bit_cnt_q == BC_WIDTH'(DATA_WIDTH - 1)) begin
                bit_cnt_d    = '0;
                data_out_d   = shift_next;
                data_valid_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    // State and pipeline registers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= IDLE;
            prod_q       <= '0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            s1_vld_q     <= 1'b0;
            acc_q        <= '0;
            s2_vld_q     <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prod_q       <= prod_d;
            first_q      <= first_d;
            last_q       <= last_d;
            s1_vld_q     <= s1_vld_d;
            acc_q        <= acc_d;
            s2_vld_q     <= s2_vld_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Self-checking bench for bpsk_demodulator: the expected bit of each symbol is the
// sign of the plain correlation sum of the samples actually driven.
module tb_bpsk_demodulator;

    logic               clk = 1'b0;
    logic               arst;
    logic               en;
    logic signed [11:0] signal_in;
    logic signed [11:0] sine_in;
    logic [7:0]         cnt_in;
    logic               bit_out;
    logic               bit_valid;
    logic [11:0]        data_out;
    logic               data_valid;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc = 0;
    longint last_drive_cyc = 0;
    int     sine_tab[256];

    logic   bq[$];
    longint bt[$];
    logic [11:0] wq[$];
    longint wt[$];

    bpsk_demodulator #(
        .SAMPLE_NUMBER(256),
        .SAMPLE_WIDTH (12),
        .DATA_WIDTH   (12)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .en        (en),
        .signal_in (signal_in),
        .sine_in   (sine_in),
        .cnt_in    (cnt_in),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .data_out  (data_out),
        .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid pulse with the cycle it was seen in
    always @(negedge clk) begin
        if (bit_valid) begin
            bq.push_back(bit_out);
            bt.push_back(cyc);
        end
        if (data_valid) begin
            wq.push_back(data_out);
            wt.push_back(cyc);
        end
    end

    task automatic clear_scoreboard();
        bq.delete(); bt.delete(); wq.delete(); wt.delete();
    endtask

    task automatic drive_sample(input logic e, input int s, input int sn, input int c);
        @(negedge clk);
        en        = e;
        signal_in = 12'(s);
        sine_in   = 12'(sn);
        cnt_in    = 8'(c);
        last_drive_cyc = cyc;
    endtask

    // kind: 0 = -sine, 1 = +sine, 2 = full-scale negative on both inputs, 3 = silence
    task automatic drive_partial(input int kind, input bit noise, input int c0, input int c1,
                                 output logic b);
        longint sum = 0;
        int s, sn, amp;
        amp = noise ? int'($urandom_range(600, 2047)) : 2047;
        for (int c = c0; c <= c1; c++) begin
            sn = sine_tab[c];
            case (kind)
                0:       s = -(sn * amp) / 2047;
                1:       s = (sn * amp) / 2047;
                2:       begin s = -2048; sn = -2048; end
                default: s = 0;
            endcase
            if (noise && kind < 2) s = s + int'($urandom_range(0, 400)) - 200;
            if (s > 2047)  s = 2047;
            if (s < -2048) s = -2048;
            sum += longint'(s) * longint'(sn);
            drive_sample(1'b1, s, sn, c);
        end
        b = (sum > 0);
    endtask

    task automatic drive_symbol(input int kind, input bit noise, output logic b);
        drive_partial(kind, noise, 0, 255, b);
    endtask

    task automatic send_word(input logic [11:0] w, input bit noise, output logic [11:0] model);
        logic b;
        model = '0;
        for (int i = 11; i >= 0; i--) begin
            drive_symbol(int'(w[i]), noise, b);
            model = {model[10:0], b};
        end
    endtask

    // Keep en high long enough for the last bit to leave the pipeline, then stop
    task automatic flush();
        for (int c = 0; c < 4; c++) drive_sample(1'b1, 0, sine_tab[c], c);
        for (int c = 4; c < 6; c++) drive_sample(1'b0, 0, sine_tab[c], c);
    endtask

    task automatic test_reset();
        arst = 1'b1; en = 1'b0; signal_in = '0; sine_in = '0; cnt_in = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bit_out, bit_valid, data_out, data_valid} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b_%b_%h_%b, want all zero",
                     bit_out, bit_valid, data_out, data_valid);
        end
        @(negedge clk); arst = 1'b0;
    endtask

    task automatic test_loopback();
        logic [11:0] model;
        logic [11:0] exp_w = 12'hA5C;
        longint t_last;
        clear_scoreboard();
        send_word(exp_w, 1'b0, model);
        t_last = last_drive_cyc;
        flush();
        n_checks++;
        if (bq.size() !== 12) begin
            n_fail++;
            $display("FAIL loopback_bit_count: got %0d, want 12", bq.size());
        end
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (i >= bq.size() || bq[i] !== exp_w[11-i]) begin
                n_fail++;
                $display("FAIL loopback_bit%0d: got %b, want %b", i,
                         (i < bq.size()) ? bq[i] : 1'bx, exp_w[11-i]);
            end
        end
        n_checks++;
        if (wq.size() !== 1 || wq[0] !== exp_w) begin
            n_fail++;
            $display("FAIL loopback_word: got %0d words first=%h, want 1 word %h",
                     wq.size(), (wq.size() > 0) ? wq[0] : 12'hxxx, exp_w);
        end
        n_checks++;
        if (bt.size() != 12 || bt[11] != t_last + 3) begin
            n_fail++;
            $display("FAIL loopback_latency: got cycle %0d, want %0d",
                     (bt.size() == 12) ? bt[11] : -1, t_last + 3);
        end
        n_checks++;
        if (wt.size() != 1 || bt.size() != 12 || wt[0] != bt[11]) begin
            n_fail++;
            $display("FAIL loopback_valid_align: data_valid at %0d, last bit_valid at %0d",
                     (wt.size() > 0) ? wt[0] : -1, (bt.size() > 0) ? bt[bt.size()-1] : -1);
        end
    endtask

    task automatic test_reset_mid();
        logic b;
        for (int k = 0; k < 2; k++) drive_symbol(int'($urandom_range(0, 1)), 1'b1, b);
        drive_partial(1, 1'b1, 0, 50, b);
        @(negedge clk); #2 arst = 1'b1; en = 1'b0;
        #1;
        n_checks++;
        if ({bit_out, bit_valid, data_out, data_valid} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %b_%b_%h_%b, want all zero",
                     bit_out, bit_valid, data_out, data_valid);
        end
        @(negedge clk); arst = 1'b0;
        clear_scoreboard();
        for (int c = 0; c < 5; c++) drive_sample(1'b0, 1000, sine_tab[c], 0);
        for (int c = 10; c < 256; c++) drive_sample(1'b1, sine_tab[c], sine_tab[c], c);
        for (int c = 0; c < 5; c++) drive_sample(1'b0, 0, sine_tab[c], c);
        n_checks++;
        if (bq.size() != 0 || wq.size() != 0) begin
            n_fail++;
            $display("FAIL reset_no_pulse: got %0d bit / %0d word pulses, want 0 / 0",
                     bq.size(), wq.size());
        end
    endtask

    task automatic test_fullscale();
        logic b;
        clear_scoreboard();
        for (int k = 0; k < 12; k++) drive_symbol(2, 1'b0, b);
        for (int k = 0; k < 12; k++) drive_symbol(3, 1'b0, b);
        flush();
        n_checks++;
        if (wq.size() != 2 || wq[0] !== 12'hFFF) begin
            n_fail++;
            $display("FAIL fullscale_word: got %0d words first=%h, want FFF",
                     wq.size(), (wq.size() > 0) ? wq[0] : 12'hxxx);
        end
        n_checks++;
        if (wq.size() != 2 || wq[1] !== 12'h000) begin
            n_fail++;
            $display("FAIL zero_tie_word: got %0d words second=%h, want 000",
                     wq.size(), (wq.size() > 1) ? wq[1] : 12'hxxx);
        end
    endtask

    task automatic test_late_start();
        logic [11:0] model;
        logic [11:0] w;
        w = 12'($urandom);
        clear_scoreboard();
        for (int c = 100; c < 256; c++)
            drive_sample(1'b1, int'($urandom_range(0, 4095)) - 2048, sine_tab[c], c);
        send_word(w, 1'b1, model);
        flush();
        n_checks++;
        if (bq.size() != 12) begin
            n_fail++;
            $display("FAIL late_start_bits: got %0d, want 12", bq.size());
        end
        n_checks++;
        if (wq.size() != 1 || wq[0] !== model) begin
            n_fail++;
            $display("FAIL late_start_word: got %0d words first=%h, want %h",
                     wq.size(), (wq.size() > 0) ? wq[0] : 12'hxxx, model);
        end
    endtask

    task automatic test_en_drop();
        logic [11:0] model;
        logic [11:0] w;
        logic b;
        w = 12'($urandom);
        clear_scoreboard();
        for (int k = 0; k < 5; k++) drive_symbol(int'($urandom_range(0, 1)), 1'b1, b);
        drive_sample(1'b1, 500, sine_tab[0], 0);
        drive_sample(1'b1, 500, sine_tab[1], 1);
        for (int c = 2; c < 5; c++) drive_sample(1'b0, 500, sine_tab[c], c);
        send_word(w, 1'b1, model);
        flush();
        n_checks++;
        if (bq.size() != 17) begin
            n_fail++;
            $display("FAIL en_drop_bits: got %0d, want 17", bq.size());
        end
        n_checks++;
        if (wq.size() != 1 || wq[0] !== model) begin
            n_fail++;
            $display("FAIL en_drop_word: got %0d words first=%h, want 1 word %h",
                     wq.size(), (wq.size() > 0) ? wq[0] : 12'hxxx, model);
        end
    endtask

    task automatic test_discontinuity();
        logic [11:0] model = '0;
        logic b;
        clear_scoreboard();
        for (int k = 0; k < 3; k++) begin
            drive_symbol(int'($urandom_range(0, 1)), 1'b1, b);
            model = {model[10:0], b};
        end
        drive_partial(int'($urandom_range(0, 1)), 1'b1, 0, 99, b);
        for (int k = 0; k < 9; k++) begin
            drive_symbol(int'($urandom_range(0, 1)), 1'b1, b);
            model = {model[10:0], b};
        end
        flush();
        n_checks++;
        if (bq.size() != 12) begin
            n_fail++;
            $display("FAIL discontinuity_bits: got %0d, want 12", bq.size());
        end
        n_checks++;
        if (wq.size() != 1 || wq[0] !== model) begin
            n_fail++;
            $display("FAIL discontinuity_word: got %0d words first=%h, want %h",
                     wq.size(), (wq.size() > 0) ? wq[0] : 12'hxxx, model);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] m1, m2;
        clear_scoreboard();
        send_word(12'h123, 1'b1, m1);
        send_word(12'hEDC, 1'b1, m2);
        flush();
        n_checks++;
        if (wq.size() != 2 || wq[0] !== m1 || wq[1] !== m2) begin
            n_fail++;
            $display("FAIL b2b_words: got %0d words %h %h, want %h %h", wq.size(),
                     (wq.size() > 0) ? wq[0] : 12'hxxx, (wq.size() > 1) ? wq[1] : 12'hxxx,
                     m1, m2);
        end
        n_checks++;
        if (wt.size() != 2 || wt[1] - wt[0] != 3072) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles, want 3072",
                     (wt.size() == 2) ? wt[1] - wt[0] : -1);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            sine_tab[i] = int'(2047.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 256.0));
        test_reset();
        test_loopback();
        test_reset_mid();
        test_fullscale();
        test_late_start();
        test_en_drop();
        test_discontinuity();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
